// File: rtl/ahb_sram_subordinate.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_subordinate
// Purpose  : AHB-Lite subordinate in front of a word-organised SRAM. It adds a
//            programmable number of wait states to every valid data phase,
//            supports byte/halfword/word writes through byte lanes, and returns
//            a two-cycle ERROR response for illegal sizes, misaligned or
//            out-of-range addresses.
// Ports    : clk     - clock, all state changes on the rising edge
//            reset   - asynchronous, active-low reset (control state only)
//            HSEL    - subordinate select
//            HADDR   - byte address (address phase)
//            HTRANS  - transfer type (IDLE/BUSY/NONSEQ/SEQ)
//            HWRITE  - 1 = write
//            HSIZE   - 000 byte, 001 halfword, 010 word
//            HWDATA  - write data (data phase)
//            HRDATA  - read data, non-zero only in the completing cycle
//            HREADY  - data phase complete (also the bus HREADY)
//            HRESP   - 0 OKAY, 1 ERROR
// Revision : 1.0 - initial release
// ============================================================================
module ahb_sram_subordinate #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  localparam int          c_idx_w     = $clog2(DEPTH_WORDS);
  localparam logic [29:0] c_depth     = 30'(DEPTH_WORDS);
  localparam logic [3:0]  c_wait_last = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_wait = 3'd1;
  localparam logic [2:0] c_st_xfer = 3'd2;
  localparam logic [2:0] c_st_err1 = 3'd3;
  localparam logic [2:0] c_st_err2 = 3'd4;

  logic [2:0]         r_state;
  logic [2:0]         w_next;
  logic [3:0]         r_wait_cnt;
  logic [c_idx_w-1:0] r_idx;
  logic [1:0]         r_lane;
  logic [1:0]         r_size;
  logic               r_write;

  logic [31:0]        mem [DEPTH_WORDS];

  logic [32:0]        w_diff;
  logic               w_err;
  logic               w_active;
  logic               w_accept;
  logic [3:0]         w_lane_en;

  // One extra bit so an address below BASE_ADDR shows up as a borrow instead
  // of wrapping into a large, apparently in-range offset. BASE_ADDR is assumed
  // word aligned, so w_diff[1:0] equals HADDR[1:0].
  assign w_diff = {1'b0, HADDR} - {1'b0, BASE_ADDR};

  assign w_err = HSIZE[2]
               | (HSIZE[1:0] == 2'b11)
               | ((HSIZE[1:0] == 2'b01) & HADDR[0])
               | ((HSIZE[1:0] == 2'b10) & (HADDR[1:0] != 2'b00))
               | w_diff[32]
               | (w_diff[31:2] >= c_depth);

  assign w_active = HSEL && ((HTRANS == 2'b10) || (HTRANS == 2'b11));
  assign w_accept = HREADY && w_active;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next;
    end
  end

  // Wait counter: counts cycles already spent in WAIT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= 4'd0;
    end else if ((r_state == c_st_wait) && (w_next == c_st_wait)) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end else begin
      r_wait_cnt <= 4'd0;
    end
  end

  // Address-phase capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx   <= '0;
      r_lane  <= 2'b00;
      r_size  <= 2'b00;
      r_write <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= w_diff[c_idx_w+1:2];
      r_lane  <= w_diff[1:0];
      r_size  <= HSIZE[1:0];
      r_write <= HWRITE;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = c_st_idle;
    case (r_state)
      c_st_idle, c_st_xfer, c_st_err2: begin
        if (w_accept) begin
          if (w_err) begin
            w_next = c_st_err1;
          end else if (WAIT_STATES == 0) begin
            w_next = c_st_xfer;
          end else begin
            w_next = c_st_wait;
          end
        end else begin
          w_next = c_st_idle;
        end
      end
      c_st_wait: w_next = (r_wait_cnt == c_wait_last) ? c_st_xfer : c_st_wait;
      c_st_err1: w_next = c_st_err2;
      default:   w_next = c_st_idle;
    endcase
  end

  // Outputs depend on state only, so an asynchronous reset forces them to
  // their idle values immediately.
  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = 32'h0;
    case (r_state)
      c_st_wait: HREADY = 1'b0;
      c_st_xfer: HRDATA = mem[r_idx];
      c_st_err1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      c_st_err2: HRESP = 1'b1;
      default: ;
    endcase
  end

  // Byte-lane enables of the registered transfer
  always_comb begin
    case (r_size)
      2'b00:   w_lane_en = 4'b0001 << r_lane;
      2'b01:   w_lane_en = 4'b0011 << r_lane;
      default: w_lane_en = 4'b1111;
    endcase
  end

  // Storage is not reset. A reset during the data phase returns r_state to
  // IDLE at once, so the pending write never reaches this block.
  always_ff @(posedge clk) begin
    if ((r_state == c_st_xfer) && r_write) begin
      if (w_lane_en[0]) mem[r_idx][7:0]   <= HWDATA[7:0];
      if (w_lane_en[1]) mem[r_idx][15:8]  <= HWDATA[15:8];
      if (w_lane_en[2]) mem[r_idx][23:16] <= HWDATA[23:16];
      if (w_lane_en[3]) mem[r_idx][31:24] <= HWDATA[31:24];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_subordinate.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_sram_subordinate
// Purpose  : Self-checking bench for ahb_sram_subordinate. Two instances
//            (0 and 2 wait states) are driven by a small AHB manager; a
//            transaction-level model predicts every cycle's outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_subordinate;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 1024;

  typedef struct {
    bit          xfer;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    bit          idle_sel;
    logic [1:0]  idle_trans;
  } item_t;

  // kind: 0 = no data expected (HRDATA must be 0), 1 = read completes, 2 = write completes
  typedef struct {
    bit          ready;
    bit          resp;
    int          kind;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(bit r, bit e, int k, logic [31:0] a, logic [2:0] s, logic [31:0] d);
    beat_t b;
    b.ready = r; b.resp = e; b.kind = k; b.addr = a; b.size = s; b.wdata = d;
    return b;
  endfunction

  function automatic bit is_err(logic [31:0] a, logic [2:0] s);
    longint unsigned av = longint'(a);
    longint unsigned lo = longint'(BASE);
    longint unsigned hi = longint'(BASE) + 4 * DEPTH;
    if (s > 3'd2) return 1'b1;
    if ((s == 3'd1) && (av % 2 != 0)) return 1'b1;
    if ((s == 3'd2) && (av % 4 != 0)) return 1'b1;
    if ((av < lo) || (av >= hi)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int widx(logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  function automatic logic [31:0] lane_mask(logic [31:0] a, logic [2:0] s);
    int sh = 8 * int'(a % 4);
    if (s == 3'd0) return 32'h0000_00FF << sh;
    if (s == 3'd1) return 32'h0000_FFFF << sh;
    return 32'hFFFF_FFFF;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int WS = (gi == 0) ? 0 : 2;

    logic        reset_n;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;
    bit          done = 1'b0;

    logic [31:0] mem_m [DEPTH];
    bit          known [DEPTH];
    item_t       items [$];
    logic [31:0] rd_q  [$];
    int          last_cycles;

    ahb_sram_subordinate #(
      .BASE_ADDR  (BASE),
      .DEPTH_WORDS(DEPTH),
      .WAIT_STATES(WS)
    ) u_dut (
      .clk   (clk),
      .reset (reset_n),
      .HSEL  (hsel),
      .HADDR (haddr),
      .HTRANS(htrans),
      .HWRITE(hwrite),
      .HSIZE (hsize),
      .HWDATA(hwdata),
      .HRDATA(hrdata),
      .HREADY(hready),
      .HRESP (hresp)
    );

    function automatic void push_w(logic [31:0] a, logic [2:0] s, logic [31:0] d);
      item_t it;
      it.xfer = 1; it.write = 1; it.addr = a; it.size = s; it.wdata = d;
      it.idle_sel = 0; it.idle_trans = 2'b00;
      items.push_back(it);
    endfunction

    function automatic void push_r(logic [31:0] a, logic [2:0] s);
      item_t it;
      it.xfer = 1; it.write = 0; it.addr = a; it.size = s; it.wdata = 32'h0;
      it.idle_sel = 0; it.idle_trans = 2'b00;
      items.push_back(it);
    endfunction

    function automatic void push_idle(bit sel, logic [1:0] tr);
      item_t it;
      it.xfer = 0; it.write = 0; it.addr = 32'h0; it.size = 3'd0; it.wdata = 32'h0;
      it.idle_sel = sel; it.idle_trans = tr;
      items.push_back(it);
    endfunction

    // Plays the queued items as a pipelined manager. Called just after a
    // rising edge; returns just after the edge that completes the last beat.
    task automatic run_seq();
      beat_t       exp_q [$];
      beat_t       e;
      item_t       cur;
      int          ai = 0;
      int          cyc = 0;
      bit          dp_write = 0;
      logic [31:0] dp_data = 32'h0;
      bit          rdy;
      string       tag;
      tag = $sformatf("ws%0d", WS);
      rd_q.delete();
      while (((ai < items.size()) || (exp_q.size() != 0)) && (cyc < 3000)) begin
        if (ai < items.size()) cur = items[ai];
        else begin
          cur.xfer = 0; cur.idle_sel = 0; cur.idle_trans = 2'b00;
        end
        hsel   = cur.xfer ? 1'b1 : cur.idle_sel;
        htrans = cur.xfer ? 2'b10 : cur.idle_trans;
        haddr  = cur.xfer ? cur.addr : $urandom;
        hwrite = cur.xfer ? cur.write : 1'($urandom);
        hsize  = cur.xfer ? cur.size : 3'($urandom);
        hwdata = dp_write ? dp_data : $urandom;
        @(negedge clk);
        e = (exp_q.size() != 0) ? exp_q[0] : mk_beat(1, 0, 0, 32'h0, 3'd0, 32'h0);
        chk({tag, "_hready"}, 32'(hready), 32'(e.ready));
        chk({tag, "_hresp"}, 32'(hresp), 32'(e.resp));
        if (e.kind == 1) begin
          if (known[widx(e.addr)]) chk({tag, "_rdata"}, hrdata, mem_m[widx(e.addr)]);
          rd_q.push_back(hrdata);
        end else if (e.kind == 0) begin
          chk({tag, "_rdata_zero"}, hrdata, 32'h0);
        end
        rdy = hready;
        @(posedge clk);
        cyc++;
        if (exp_q.size() != 0) begin
          if (exp_q[0].kind == 2) begin
            int          w = widx(exp_q[0].addr);
            logic [31:0] m = lane_mask(exp_q[0].addr, exp_q[0].size);
            mem_m[w] = (mem_m[w] & ~m) | (exp_q[0].wdata & m);
            if (exp_q[0].size == 3'd2) known[w] = 1;
          end
          void'(exp_q.pop_front());
        end
        if (rdy) begin
          dp_write = 0;
          if (ai < items.size()) begin
            if (cur.xfer) begin
              if (is_err(cur.addr, cur.size)) begin
                exp_q.push_back(mk_beat(0, 1, 0, 32'h0, 3'd0, 32'h0));
                exp_q.push_back(mk_beat(1, 1, 0, 32'h0, 3'd0, 32'h0));
              end else begin
                for (int k = 0; k < WS; k++) exp_q.push_back(mk_beat(0, 0, 0, 32'h0, 3'd0, 32'h0));
                exp_q.push_back(mk_beat(1, 0, cur.write ? 2 : 1, cur.addr, cur.size, cur.wdata));
                dp_write = cur.write;
                dp_data  = cur.wdata;
              end
            end
            ai++;
          end
        end
        #1;
      end
      if (cyc >= 3000) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s_seq_timeout: actual %0d cycles required under 3000", tag, cyc);
      end
      hsel = 0; htrans = 2'b00;
      last_cycles = cyc;
      items.delete();
    endtask

    initial begin
      string tag;
      tag = $sformatf("ws%0d", WS);
      reset_n = 0; hsel = 0; haddr = 0; htrans = 0; hwrite = 0; hsize = 0; hwdata = 0;
      for (int i = 0; i < DEPTH; i++) begin
        known[i] = 0;
        mem_m[i] = 32'h0;
      end
      #1;
      chk({tag, "_rst_hready"}, 32'(hready), 32'd1);
      chk({tag, "_rst_hresp"}, 32'(hresp), 32'd0);
      chk({tag, "_rst_hrdata"}, hrdata, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1;
      @(posedge clk);
      #1;

      // 16-beat word burst write then read back
      for (int i = 0; i < 16; i++) push_w(32'h100 + 32'(4 * i), 3'd2, 32'hA000_0000 + 32'(i));
      run_seq();
      chk({tag, "_wr16_cycles"}, 32'(last_cycles), 32'(16 * (WS + 1) + 1));
      for (int i = 0; i < 16; i++) push_r(32'h100 + 32'(4 * i), 3'd2);
      run_seq();
      chk({tag, "_rd16_cycles"}, 32'(last_cycles), 32'(16 * (WS + 1) + 1));
      chk({tag, "_rd16_count"}, 32'(rd_q.size()), 32'd16);
      for (int i = 0; i < 16; i++)
        if (i < rd_q.size()) chk({tag, "_rd16_lit"}, rd_q[i], 32'hA000_0000 + 32'(i));

      // Single read: completes WS+1 cycles after acceptance
      push_r(32'h104, 3'd2);
      run_seq();
      chk({tag, "_single_cycles"}, 32'(last_cycles), 32'(WS + 2));
      if (rd_q.size() > 0) chk({tag, "_single_lit"}, rd_q[0], 32'hA000_0001);

      // Byte and halfword lane writes
      push_w(32'h100, 3'd2, 32'h1122_3344);
      push_w(32'h102, 3'd0, 32'hEECD_EEEE);
      push_r(32'h100, 3'd2);
      push_w(32'h100, 3'd1, 32'h7777_BEEF);
      push_r(32'h100, 3'd2);
      run_seq();
      chk({tag, "_lane_count"}, 32'(rd_q.size()), 32'd2);
      if (rd_q.size() > 1) begin
        chk({tag, "_byte_lit"}, rd_q[0], 32'h11CD_3344);
        chk({tag, "_half_lit"}, rd_q[1], 32'h11CD_BEEF);
      end

      // Error responses, followed directly by normal reads
      push_w(BASE + 32'(4 * DEPTH), 3'd2, 32'hDEAD_BEEF);
      push_w(32'h100, 3'd3, 32'hDEAD_BEEF);
      push_w(32'h101, 3'd1, 32'hDEAD_BEEF);
      push_r(BASE + 32'(4 * DEPTH), 3'd2);
      push_r(32'h13C, 3'd2);
      push_r(32'h100, 3'd2);
      run_seq();
      chk({tag, "_err_cycles"}, 32'(last_cycles), 32'(1 + 8 + 2 * (WS + 1)));
      if (rd_q.size() > 1) begin
        chk({tag, "_err_rb0"}, rd_q[0], 32'hA000_000F);
        chk({tag, "_err_rb1"}, rd_q[1], 32'h11CD_BEEF);
      end else chk({tag, "_err_count"}, 32'(rd_q.size()), 32'd2);

      // Idle/busy/unselected cycles between beats
      push_w(32'h110, 3'd2, 32'h1234_5678);
      push_idle(1, 2'b00);
      push_r(32'h110, 3'd2);
      push_idle(1, 2'b01);
      push_idle(0, 2'b10);
      push_r(32'h110, 3'd2);
      run_seq();
      if (rd_q.size() > 1) begin
        chk({tag, "_idle_rb0"}, rd_q[0], 32'h1234_5678);
        chk({tag, "_idle_rb1"}, rd_q[1], 32'h1234_5678);
      end else chk({tag, "_idle_count"}, 32'(rd_q.size()), 32'd2);

      // Reset in the first data-phase cycle of a write drops the write
      hsel = 1; htrans = 2'b10; haddr = 32'h108; hwrite = 1; hsize = 3'd2;
      @(posedge clk);
      #1;
      htrans = 2'b00; hsel = 0; hwdata = 32'hFFFF_0000;
      #1;
      chk({tag, "_pre_rst_hready"}, 32'(hready), 32'(WS == 0));
      reset_n = 0;
      #1;
      chk({tag, "_mid_rst_hready"}, 32'(hready), 32'd1);
      chk({tag, "_mid_rst_hresp"}, 32'(hresp), 32'd0);
      chk({tag, "_mid_rst_hrdata"}, hrdata, 32'h0);
      @(posedge clk);
      #1;
      reset_n = 1;
      @(posedge clk);
      #1;
      push_r(32'h108, 3'd2);
      run_seq();
      if (rd_q.size() > 0) chk({tag, "_rst_drop_lit"}, rd_q[0], 32'hA000_0002);
      else chk({tag, "_rst_drop_count"}, 32'(rd_q.size()), 32'd1);

      // Randomised traffic within the 0x100..0x13F window plus error cases
      for (int n = 0; n < 150; n++) begin
        int          r = int'($urandom_range(0, 9));
        logic [31:0] a;
        logic [2:0]  s;
        if (r < 2) begin
          bit sel = 1'($urandom);
          push_idle(sel, sel ? 2'($urandom_range(0, 1)) : 2'($urandom));
        end else if (r == 2) begin
          case ($urandom_range(0, 3))
            0:       begin a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3)); s = 3'd2; end
            1:       begin a = BASE - 32'd4; s = 3'd2; end
            2:       begin a = 32'h100 + 32'($urandom_range(0, 63)); s = 3'($urandom_range(3, 7)); end
            default: begin a = 32'h101 + 32'(4 * $urandom_range(0, 15)); s = 3'($urandom_range(1, 2)); end
          endcase
          if ($urandom_range(0, 1) == 1) push_w(a, s, $urandom); else push_r(a, s);
        end else begin
          s = 3'($urandom_range(0, 2));
          a = 32'h100 + 32'(4 * $urandom_range(0, 15));
          if (s == 3'd0) a = a + 32'($urandom_range(0, 3));
          if (s == 3'd1) a = a + 32'(2 * $urandom_range(0, 1));
          if ($urandom_range(0, 1) == 1) push_w(a, s, $urandom); else push_r(a, s);
        end
      end
      run_seq();

      done = 1'b1;
    end
  end

  initial begin
    wait (g_inst[0].done && g_inst[1].done);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
